// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rf_wb_pkg                                                  |
// | Shared widths, register-zero constant and enums for the register-    |
// | file writeback arbiter.                                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package rf_wb_pkg;

    localparam int              ADDR_W   = 5;
    localparam int              DATA_W   = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // Requester index; also the value driven on rf_sel
    typedef enum logic {
        SRC_ALU  = 1'b0,
        SRC_LOAD = 1'b1
    } wb_src_e;

    // One-hot encoded output-stage state
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        WRITE = 3'b010,
        STALL = 3'b100
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : regfile_wb_arbiter_if                                    |
// | Writeback request handshakes, stall and register-file write port.   |
// | master = requester/pipeline side, slave = arbiter side.              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = rf_wb_pkg::DATA_W,
    parameter int ADDR_W = rf_wb_pkg::ADDR_W,
    parameter int CNT_W  = 16
);
    logic              wb_stall;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_sel;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output wb_stall,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_we, rf_waddr, rf_wdata, rf_sel, conflict_cnt
    );

    modport slave (
        input  wb_stall,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_we, rf_waddr, rf_wdata, rf_sel, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter_2                                               |
// | Two-way round-robin arbiter: combinational grant plus the flop that  |
// | remembers the last winner. rr_last resets to 1 so req[0] wins the    |
// | first contention.                                                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_arbiter_2
    import rf_wb_pkg::*;
(
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic [1:0] req,
    input  wire logic       enable,
    output logic      [1:0] gnt,
    output logic            gnt_idx
);

    wb_src_e r_rr_last;

    // Grant the lone requester, or the one that did not win last time
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_rr_last == SRC_LOAD) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt_idx = gnt[1];

    // Remember the winner, only when a grant is actually issued
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_last <= SRC_LOAD;
        end else if (|gnt) begin
            r_rr_last <= wb_src_e'(gnt_idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_wb_arbiter                                         |
// | Shares the register-file write port between the ALU (req0) and the  |
// | load unit (req1) with round-robin arbitration and one registered    |
// | output stage.                                                        |
// | Optional feature macro: RF_WB_CONFLICT_CNT_EN (contention counter). |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter #(
    parameter int DATA_W = rf_wb_pkg::DATA_W,
    parameter int ADDR_W = rf_wb_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  wire logic            clock,
    input  wire logic            reset,
    regfile_wb_arbiter_if.slave  bus
);
    import rf_wb_pkg::*;

    localparam logic [ADDR_W-1:0] c_reg_zero = ADDR_W'(REG_ZERO);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_gnt_idx;
    logic              w_enable;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    wb_state_e         r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    wb_src_e           r_sel;

    assign w_req    = {bus.req1_valid, bus.req0_valid};
    // No grants while stalled or while reset is held
    assign w_enable = !bus.wb_stall && !reset;

    rr_arbiter_2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (w_req),
        .enable  (w_enable),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Grants only ever cover valid requesters, so ready implies valid
    assign bus.req0_ready = w_gnt[0];
    assign bus.req1_ready = w_gnt[1];
    assign w_accept       = |w_gnt;
    assign w_addr         = w_gnt_idx ? bus.req1_addr : bus.req0_addr;
    assign w_data         = w_gnt_idx ? bus.req1_data : bus.req0_data;

    // Output stage FSM: load on accept, write-enable only for nonzero destinations
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_sel   <= SRC_ALU;
        end else begin
            case (r_state)
                IDLE, WRITE, STALL: begin
                    if (bus.wb_stall)  r_state <= STALL;
                    else if (w_accept) r_state <= WRITE;
                    else               r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // Register 0 is accepted and recorded but never written
            r_we <= w_accept && (w_addr != c_reg_zero);
            if (w_accept) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
                r_sel   <= wb_src_e'(w_gnt_idx);
            end
        end
    end

    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;
    assign bus.rf_sel   = r_sel;

`ifdef RF_WB_CONFLICT_CNT_EN
    logic [CNT_W-1:0] r_conflict_cnt;

    // Count unstalled cycles where both requesters compete, saturating
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if ((&w_req) && !bus.wb_stall && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign bus.conflict_cnt = r_conflict_cnt;
`else
    assign bus.conflict_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_regfile_wb_arbiter                                      |
// | Self-checking bench for regfile_wb_arbiter with a behavioural model  |
// | of the round-robin writeback rules. Honours RF_WB_CONFLICT_CNT_EN.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
    import rf_wb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
`ifdef RF_WB_CONFLICT_CNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2))  bus2 ();

    // Second instance sees identical stimulus; only its counter is narrower
    assign bus2.wb_stall   = bus.wb_stall;
    assign bus2.req0_valid = bus.req0_valid;
    assign bus2.req0_addr  = bus.req0_addr;
    assign bus2.req0_data  = bus.req0_data;
    assign bus2.req1_valid = bus.req1_valid;
    assign bus2.req1_addr  = bus.req1_addr;
    assign bus2.req1_data  = bus.req1_data;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) u_dut (
        .clock (clock), .reset (reset), .bus (bus.slave));
    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) u_dut2 (
        .clock (clock), .reset (reset), .bus (bus2.slave));

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int            m_last;
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_sel;
    int            m_cnt;
    int            m_cnt2;

    task automatic model_reset();
        m_last = 1; m_we = 0; m_waddr = '0; m_wdata = '0; m_sel = 0;
        m_cnt = 0; m_cnt2 = 0;
    endtask

    // Which requester the rules say wins with the present inputs (-1 = none)
    function automatic int winner();
        if (reset || bus.wb_stall) return -1;
        if (bus.req0_valid && bus.req1_valid) return 1 - m_last;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_clock();
        int w;
        w = winner();
        if (reset) begin
            model_reset();
        end else begin
            if (FEAT && bus.req0_valid && bus.req1_valid && !bus.wb_stall) begin
                if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
            m_we = 0;
            if (w >= 0) begin
                m_waddr = (w == 0) ? bus.req0_addr : bus.req1_addr;
                m_wdata = (w == 0) ? bus.req0_data : bus.req1_data;
                m_sel   = w;
                m_last  = w;
                m_we    = (m_waddr != 0);
            end
        end
    endtask

    // Step to just after the next rising edge, keeping the model in lockstep
    task automatic advance();
        @(posedge clock);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_stall = 0; bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_addr = '0; bus.req0_data = '0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        bus.req0_valid = 1; bus.req0_addr = 5'd7; bus.req0_data = 32'hA5A5_0007;
        bus.req1_valid = 1; bus.req1_addr = 5'd9; bus.req1_data = 32'h5A5A_0009;
        model_reset();
        @(negedge clock);
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
        checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== '0 || bus.rf_wdata !== '0 || bus.rf_sel !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: got we=%b a=%0d d=%h s=%b want all 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_sel); end
        checks++; if (bus.conflict_cnt !== '0 || bus2.conflict_cnt !== '0)
            begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0", bus.conflict_cnt, bus2.conflict_cnt); end
        advance();
        reset = 0;
        @(negedge clock);
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
            begin errors++; $display("FAIL first_grant: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        advance();
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clock);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7)
            begin errors++; $display("FAIL first_write: got we=%b a=%0d want we=1 a=7", bus.rf_we, bus.rf_waddr); end
        // Reset in the middle of the output cycle must drop the write at once
        reset = 1; model_reset();
        #1;
        checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== '0)
            begin errors++; $display("FAIL reset_midflight: got we=%b a=%0d want 0", bus.rf_we, bus.rf_waddr); end
        #1 reset = 0;
        advance();
    endtask

    task automatic test_single();
        bus.req0_valid = 1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
            begin errors++; $display("FAIL single_ready: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        advance();
        bus.req0_valid = 0;
        @(negedge clock);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD_BEEF || bus.rf_sel !== 1'b0)
            begin errors++; $display("FAIL single_write: got we=%b a=%0d d=%h s=%b want 1/5/deadbeef/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_sel); end
        advance();
        @(negedge clock);
        checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL single_hold: got we=%b a=%0d d=%h want 0/5/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        advance();
    endtask

    task automatic test_zero_reg();
        bus.req1_valid = 1; bus.req1_addr = 5'd0; bus.req1_data = 32'h0000_1234;
        @(negedge clock);
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10)
            begin errors++; $display("FAIL zero_ready: got %b want 10", {bus.req1_ready, bus.req0_ready}); end
        advance();
        bus.req1_valid = 0;
        @(negedge clock);
        checks++; if (bus.rf_we !== 1'b0 || bus.rf_sel !== 1'b1 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h1234)
            begin errors++; $display("FAIL zero_write: got we=%b s=%b a=%0d d=%h want 0/1/0/1234", bus.rf_we, bus.rf_sel, bus.rf_waddr, bus.rf_wdata); end
        advance();
    endtask

    task automatic test_contention();
        logic [AW-1:0] q0 [2];
        logic [AW-1:0] q1 [2];
        logic [DW-1:0] d0 [2];
        logic [DW-1:0] d1 [2];
        logic [AW-1:0] exp_addr [4];
        int i0, i1;
        q0[0] = 5'd1; q0[1] = 5'd2; q1[0] = 5'd3; q1[1] = 5'd4;
        exp_addr[0] = 5'd1; exp_addr[1] = 5'd3; exp_addr[2] = 5'd2; exp_addr[3] = 5'd4;
        for (int k = 0; k < 2; k++) begin d0[k] = $urandom; d1[k] = $urandom; end
        i0 = 0; i1 = 0;
        for (int k = 0; k <= 4; k++) begin
            bus.req0_valid = (i0 < 2); bus.req0_addr = q0[i0 % 2]; bus.req0_data = d0[i0 % 2];
            bus.req1_valid = (i1 < 2); bus.req1_addr = q1[i1 % 2]; bus.req1_data = d1[i1 % 2];
            @(negedge clock);
            if (k < 4) begin
                checks++; if (bus.req0_ready !== ((k % 2) == 0) || bus.req1_ready !== ((k % 2) == 1))
                    begin errors++; $display("FAIL contend_grant%0d: got %b want req%0d", k, {bus.req1_ready, bus.req0_ready}, k % 2); end
            end
            if (k > 0) begin
                checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_addr[k-1] || bus.rf_sel !== ((k - 1) % 2 == 1) ||
                              bus.rf_wdata !== (((k - 1) % 2 == 0) ? d0[(k - 1) / 2] : d1[(k - 1) / 2]))
                    begin errors++; $display("FAIL contend_write%0d: got we=%b a=%0d s=%b want a=%0d", k - 1, bus.rf_we, bus.rf_waddr, bus.rf_sel, exp_addr[k-1]); end
            end
            advance();
            if (k < 4) begin
                if (k % 2 == 0) i0++; else i1++;
            end
        end
    endtask

    task automatic test_stall();
        int exp_w;
        bus.wb_stall = 1;
        bus.req0_valid = 1; bus.req0_addr = 5'd10; bus.req0_data = $urandom;
        bus.req1_valid = 1; bus.req1_addr = 5'd11; bus.req1_data = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.rf_we !== 1'b0)
                begin errors++; $display("FAIL stall%0d: got rdy=%b we=%b want 00/0", k, {bus.req1_ready, bus.req0_ready}, bus.rf_we); end
            advance();
        end
        bus.wb_stall = 0;
        exp_w = 1 - m_last;
        @(negedge clock);
        checks++; if (bus.req0_ready !== (exp_w == 0) || bus.req1_ready !== (exp_w == 1))
            begin errors++; $display("FAIL stall_release: got %b want req%0d", {bus.req1_ready, bus.req0_ready}, exp_w); end
        advance();
        if (exp_w == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
        @(negedge clock);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_sel !== (exp_w == 1))
            begin errors++; $display("FAIL stall_write: got we=%b s=%b want 1/%0d", bus.rf_we, bus.rf_sel, exp_w); end
        advance();
        idle_inputs();
        advance();
    endtask

    // Random traffic; requesters hold until accepted. Every cycle is checked against the model.
    task automatic test_random(input int n, input bit force_both, input int stall_a, input int stall_b);
        bit p0, p1;
        int w;
        p0 = 0; p1 = 0;
        for (int i = 0; i < n; i++) begin
            if (!p0 && (force_both || $urandom_range(0, 2) != 0)) begin
                p0 = 1; bus.req0_addr = AW'($urandom_range(0, 31)); bus.req0_data = $urandom;
            end
            if (!p1 && (force_both || $urandom_range(0, 2) != 0)) begin
                p1 = 1; bus.req1_addr = AW'($urandom_range(0, 31)); bus.req1_data = $urandom;
            end
            bus.req0_valid = p0; bus.req1_valid = p1;
            if (force_both) bus.wb_stall = (i == stall_a) || (i == stall_b);
            else            bus.wb_stall = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            w = winner();
            checks++; if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1))
                begin errors++; $display("FAIL rand_ready@%0d: got %b want winner %0d", i, {bus.req1_ready, bus.req0_ready}, w); end
            checks++; if (bus.rf_we !== m_we || bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata || bus.rf_sel !== (m_sel == 1))
                begin errors++; $display("FAIL rand_out@%0d: got we=%b a=%0d d=%h s=%b want we=%b a=%0d d=%h s=%0d", i,
                    bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_sel, m_we, m_waddr, m_wdata, m_sel); end
            checks++; if (bus.conflict_cnt !== CW'(m_cnt) || bus2.conflict_cnt !== 2'(m_cnt2))
                begin errors++; $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d", i, bus.conflict_cnt, bus2.conflict_cnt, m_cnt, m_cnt2); end
            advance();
            if (w == 0) p0 = 0;
            if (w == 1) p1 = 0;
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_conflict_cnt();
        reset = 1; idle_inputs(); model_reset();
        advance();
        reset = 0;
        test_random(10, 1'b1, 3, 7);
        @(negedge clock);
        checks++; if (bus.conflict_cnt !== (FEAT ? CW'(8) : CW'(0)))
            begin errors++; $display("FAIL conflict_cnt: got %0d want %0d", bus.conflict_cnt, FEAT ? 8 : 0); end
        checks++; if (bus2.conflict_cnt !== (FEAT ? 2'd3 : 2'd0))
            begin errors++; $display("FAIL conflict_sat: got %0d want %0d", bus2.conflict_cnt, FEAT ? 3 : 0); end
        advance();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_reg();
        test_contention();
        test_stall();
        test_random(400, 1'b0, 0, 0);
        test_conflict_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
